// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: default widths, mul/div function codes
// and the reservation-station entry payload.
package tomasulo_pkg;

    localparam int DATA_W = 8;
    localparam int REG_W  = 4;
    localparam int ROB_W  = 3;

    localparam logic [3:0] FUNC_MUL = 4'b0010;
    localparam logic [3:0] FUNC_DIV = 4'b0011;

    typedef struct packed {
        logic [3:0]        func;
        logic [REG_W-1:0]  rd;
        logic [ROB_W-1:0]  rob_ind;
        logic              rs1_rdy;
        logic [REG_W-1:0]  rs1_tag;
        logic [DATA_W-1:0] rs1_data;
        logic              rs2_rdy;
        logic [REG_W-1:0]  rs2_tag;
        logic [DATA_W-1:0] rs2_data;
    } rs_entry_t;

endpackage

// File: rtl/mul_rs_entry.sv
// One mul/div reservation-station entry: issue write with CDB bypass,
// per-operand CDB wakeup and an all-operands-ready flag.
module mul_rs_entry
    import tomasulo_pkg::*;
(
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              wr_en,
    input  rs_entry_t         wr_ent,
    input  logic              clr,
    input  logic              cdb_valid,
    input  logic [REG_W-1:0]  cdb_rd,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              valid,
    output rs_entry_t         ent,
    output logic              ready
);

    rs_entry_t wr_byp;
    logic      wake1;
    logic      wake2;

    // An operand whose producer broadcasts in the issue cycle is captured directly.
    always_comb begin
        wr_byp = wr_ent;
        if (cdb_valid && !wr_ent.rs1_rdy && (wr_ent.rs1_tag == cdb_rd)) begin
            wr_byp.rs1_rdy  = 1'b1;
            wr_byp.rs1_data = cdb_data;
        end
        if (cdb_valid && !wr_ent.rs2_rdy && (wr_ent.rs2_tag == cdb_rd)) begin
            wr_byp.rs2_rdy  = 1'b1;
            wr_byp.rs2_data = cdb_data;
        end
    end

    assign wake1 = valid && cdb_valid && !ent.rs1_rdy && (ent.rs1_tag == cdb_rd);
    assign wake2 = valid && cdb_valid && !ent.rs2_rdy && (ent.rs2_tag == cdb_rd);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            ent   <= '0;
        end else if (wr_en) begin
            valid <= 1'b1;
            ent   <= wr_byp;
        end else begin
            if (clr) begin
                valid <= 1'b0;
            end
            if (wake1) begin
                ent.rs1_rdy  <= 1'b1;
                ent.rs1_data <= cdb_data;
            end
            if (wake2) begin
                ent.rs2_rdy  <= 1'b1;
                ent.rs2_data <= cdb_data;
            end
        end
    end

    assign ready = valid && ent.rs1_rdy && ent.rs2_rdy;

endmodule

// File: rtl/mul_rs_dispatch.sv
// Mul/div reservation station: holds issued ops, wakes operands from the CDB and
// dispatches the oldest ready op to the execution unit. MUL_RS_FLUSH_EN adds a flush input.
module mul_rs_dispatch
    import tomasulo_pkg::*;
#(
    parameter int NUM_ENT = 3,
    parameter int DATA_W  = tomasulo_pkg::DATA_W,
    parameter int REG_W   = tomasulo_pkg::REG_W,
    parameter int ROB_W   = tomasulo_pkg::ROB_W
) (
    input  logic              clk1,
    input  logic              rst_n,
`ifdef MUL_RS_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [3:0]        issue_func,
    input  logic [REG_W-1:0]  issue_rd,
    input  logic [ROB_W-1:0]  issue_rob_ind,
    input  logic              issue_rs1_rdy,
    input  logic              issue_rs2_rdy,
    input  logic [REG_W-1:0]  issue_rs1_tag,
    input  logic [REG_W-1:0]  issue_rs2_tag,
    input  logic [DATA_W-1:0] issue_rs1_data,
    input  logic [DATA_W-1:0] issue_rs2_data,
    input  logic              cdb_valid,
    input  logic [REG_W-1:0]  cdb_rd,
    input  logic [15:0]       cdb_data,
    input  logic              exec_done,
    output logic              ex_b,
    output logic [ROB_W-1:0]  rs_index,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [3:0]        func,
    output logic [REG_W-1:0]  rd,
    output logic [ROB_W-1:0]  rob_ind,
    output logic [1:0]        mul_count
);

    localparam int IDX_W = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;
    localparam logic [1:0] FULL_CNT = 2'(NUM_ENT);

    logic [NUM_ENT-1:0] ent_valid;
    logic [NUM_ENT-1:0] ent_ready;
    logic [NUM_ENT-1:0] ent_wr;
    logic [NUM_ENT-1:0] ent_clr;
    rs_entry_t          ents [NUM_ENT];
    logic [IDX_W-1:0]   age  [NUM_ENT];

    rs_entry_t        iss_ent;
    logic             busy;
    logic [1:0]       count;
    logic [1:0]       survivors;
    logic             flush_now;
    logic             do_issue;
    logic             do_disp;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] free_idx;
    logic             cdb_hi_unused;

`ifdef MUL_RS_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    assign cdb_hi_unused = ^cdb_data[15:DATA_W];

    assign iss_ent = '{func: issue_func, rd: issue_rd, rob_ind: issue_rob_ind,
                       rs1_rdy: issue_rs1_rdy, rs1_tag: issue_rs1_tag, rs1_data: issue_rs1_data,
                       rs2_rdy: issue_rs2_rdy, rs2_tag: issue_rs2_tag, rs2_data: issue_rs2_data};

    // Age 0 is the oldest held op; ages of valid entries are always distinct.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        free_idx  = '0;
        for (int unsigned i = 0; i < NUM_ENT; i++) begin
            if (ent_ready[i] && !busy && (!sel_found || (age[i] < age[sel_idx]))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
        for (int unsigned i = NUM_ENT; i > 0; i--) begin
            if (!ent_valid[i-1]) begin
                free_idx = IDX_W'(i - 1);
            end
        end
    end

    assign issue_ready = (count < FULL_CNT);
    assign do_issue    = issue_valid && issue_ready && !flush_now;
    assign do_disp     = sel_found && !flush_now;
    assign survivors   = count - {1'b0, do_disp};
    assign mul_count   = count;

    for (genvar g = 0; g < NUM_ENT; g++) begin : g_ent
        assign ent_wr[g]  = do_issue && (free_idx == IDX_W'(g));
        assign ent_clr[g] = flush_now || (do_disp && (sel_idx == IDX_W'(g)));

        mul_rs_entry u_ent (
            .clk1      (clk1),
            .rst_n     (rst_n),
            .wr_en     (ent_wr[g]),
            .wr_ent    (iss_ent),
            .clr       (ent_clr[g]),
            .cdb_valid (cdb_valid),
            .cdb_rd    (cdb_rd),
            .cdb_data  (cdb_data[DATA_W-1:0]),
            .valid     (ent_valid[g]),
            .ent       (ents[g]),
            .ready     (ent_ready[g])
        );
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            ex_b     <= 1'b0;
            rs_index <= '0;
            rs1_data <= '0;
            rs2_data <= '0;
            func     <= '0;
            rd       <= '0;
            rob_ind  <= '0;
            count    <= '0;
            for (int unsigned i = 0; i < NUM_ENT; i++) begin
                age[i] <= '0;
            end
        end else begin
            ex_b <= do_disp;
            if (do_disp) begin
                busy     <= 1'b1;
                rs_index <= ROB_W'(sel_idx);
                rs1_data <= ents[sel_idx].rs1_data;
                rs2_data <= ents[sel_idx].rs2_data;
                func     <= ents[sel_idx].func;
                rd       <= ents[sel_idx].rd;
                rob_ind  <= ents[sel_idx].rob_ind;
            end else if (exec_done) begin
                busy <= 1'b0;
            end

            if (flush_now) begin
                count <= '0;
            end else begin
                count <= survivors + {1'b0, do_issue};
            end

            // Removing any entry closes its gap in the age order; a new op goes to the back.
            for (int unsigned i = 0; i < NUM_ENT; i++) begin
                if (ent_wr[i]) begin
                    age[i] <= IDX_W'(survivors);
                end else if (do_disp && ent_valid[i] && (age[i] > age[sel_idx])) begin
                    age[i] <= age[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_rs_dispatch.sv
// Self-checking bench for mul_rs_dispatch: directed scenarios plus randomized
// traffic against an in-bench sequence-number model of the station.
module tb_mul_rs_dispatch;
    import tomasulo_pkg::*;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [3:0]  issue_func = '0;
    logic [3:0]  issue_rd = '0;
    logic [2:0]  issue_rob_ind = '0;
    logic        issue_rs1_rdy = 1'b0, issue_rs2_rdy = 1'b0;
    logic [3:0]  issue_rs1_tag = '0, issue_rs2_tag = '0;
    logic [7:0]  issue_rs1_data = '0, issue_rs2_data = '0;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_rd = '0;
    logic [15:0] cdb_data = '0;
    logic        exec_done = 1'b0;
    logic        ex_b;
    logic [2:0]  rs_index;
    logic [7:0]  rs1_data, rs2_data;
    logic [3:0]  func;
    logic [3:0]  rd;
    logic [2:0]  rob_ind;
    logic [1:0]  mul_count;

    int total = 0;
    int bad = 0;

    always #5 clk1 = ~clk1;

    mul_rs_dispatch #(.NUM_ENT(3), .DATA_W(8), .REG_W(4), .ROB_W(3)) dut (
        .clk1(clk1), .rst_n(rst_n),
`ifdef MUL_RS_FLUSH_EN
        .flush(flush),
`endif
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_func(issue_func),
        .issue_rd(issue_rd), .issue_rob_ind(issue_rob_ind),
        .issue_rs1_rdy(issue_rs1_rdy), .issue_rs2_rdy(issue_rs2_rdy),
        .issue_rs1_tag(issue_rs1_tag), .issue_rs2_tag(issue_rs2_tag),
        .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
        .cdb_valid(cdb_valid), .cdb_rd(cdb_rd), .cdb_data(cdb_data),
        .exec_done(exec_done), .ex_b(ex_b), .rs_index(rs_index),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .func(func), .rd(rd),
        .rob_ind(rob_ind), .mul_count(mul_count)
    );

    // Non mul/div codes are passed through, but worth flagging when seen.
    always @(negedge clk1) begin
        if (rst_n && ex_b)
            assert (func == FUNC_MUL || func == FUNC_DIV)
            else $warning("non mul/div function dispatched: %b", func);
    end

    // Reference model: held ops ordered by issue sequence number.
    typedef struct {
        bit         v;
        logic [3:0] func;
        logic [3:0] rd;
        logic [2:0] rob;
        bit         r1, r2;
        logic [3:0] t1, t2;
        logic [7:0] d1, d2;
        int         seq;
    } m_ent_t;

    m_ent_t     m [3];
    int         seq_ctr = 0;
    bit         m_busy = 0, m_exb = 0;
    int         m_idx = 0;
    logic [7:0] m_d1 = '0, m_d2 = '0;
    logic [3:0] m_func = '0, m_rd = '0;
    logic [2:0] m_rob = '0;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 3; i++) if (m[i].v) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m[i].v = 0;
        m_busy = 0; m_exb = 0; m_idx = 0;
        m_d1 = '0; m_d2 = '0; m_func = '0; m_rd = '0; m_rob = '0;
    endtask

    // Advance model over one edge using current inputs, then let the DUT take the edge.
    task automatic tick();
        int ch = -1;
        int fr = -1;
        bit acc;
        if (!flush)
            for (int i = 0; i < 3; i++)
                if (m[i].v && m[i].r1 && m[i].r2 && !m_busy && (ch < 0 || m[i].seq < m[ch].seq)) ch = i;
        acc = issue_valid && !flush && (m_count() < 3);
        for (int i = 0; i < 3; i++) if (!m[i].v && fr < 0) fr = i;
        m_exb = (ch >= 0);
        if (ch >= 0) begin
            m_idx = ch; m_d1 = m[ch].d1; m_d2 = m[ch].d2;
            m_func = m[ch].func; m_rd = m[ch].rd; m_rob = m[ch].rob;
            m[ch].v = 0;
        end
        if (cdb_valid)
            for (int i = 0; i < 3; i++) if (m[i].v) begin
                if (!m[i].r1 && m[i].t1 == cdb_rd) begin m[i].r1 = 1; m[i].d1 = cdb_data[7:0]; end
                if (!m[i].r2 && m[i].t2 == cdb_rd) begin m[i].r2 = 1; m[i].d2 = cdb_data[7:0]; end
            end
        if (flush) for (int i = 0; i < 3; i++) m[i].v = 0;
        if (acc) begin
            m[fr].v = 1; m[fr].func = issue_func; m[fr].rd = issue_rd; m[fr].rob = issue_rob_ind;
            m[fr].r1 = issue_rs1_rdy; m[fr].t1 = issue_rs1_tag; m[fr].d1 = issue_rs1_data;
            m[fr].r2 = issue_rs2_rdy; m[fr].t2 = issue_rs2_tag; m[fr].d2 = issue_rs2_data;
            if (cdb_valid && !m[fr].r1 && m[fr].t1 == cdb_rd) begin m[fr].r1 = 1; m[fr].d1 = cdb_data[7:0]; end
            if (cdb_valid && !m[fr].r2 && m[fr].t2 == cdb_rd) begin m[fr].r2 = 1; m[fr].d2 = cdb_data[7:0]; end
            m[fr].seq = seq_ctr++;
        end
        if (ch >= 0) m_busy = 1;
        else if (exec_done) m_busy = 0;
        @(posedge clk1);
        #1;
    endtask

    task automatic set_issue(input logic [3:0] f, input logic [3:0] d, input logic [2:0] rob,
                             input bit r1, input logic [3:0] t1, input logic [7:0] d1,
                             input bit r2, input logic [3:0] t2, input logic [7:0] d2);
        issue_valid = 1; issue_func = f; issue_rd = d; issue_rob_ind = rob;
        issue_rs1_rdy = r1; issue_rs1_tag = t1; issue_rs1_data = d1;
        issue_rs2_rdy = r2; issue_rs2_tag = t2; issue_rs2_data = d2;
    endtask

    task automatic idle();
        issue_valid = 0; cdb_valid = 0; exec_done = 0; flush = 0;
    endtask

    task automatic drain();
        bit done = 0;
        idle();
        exec_done = 1;
        for (int k = 0; k < 64 && !done; k++) begin
            cdb_valid = 1; cdb_rd = 4'(k); cdb_data = 16'(k * 3);
            tick();
            done = (m_count() == 0) && !m_busy;
        end
        idle();
        total++;
        if (!done) begin bad++; $display("FAIL drain: station not empty, count=%0d required 0", mul_count); end
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 0;
        #12;
        total += 6;
        if (ex_b !== 1'b0) begin bad++; $display("FAIL reset_ex_b got=%b exp=0", ex_b); end
        if (mul_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", mul_count); end
        if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
        if (rs_index !== 3'd0 || rob_ind !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d/%0d exp=0/0", rs_index, rob_ind); end
        if (rs1_data !== 8'd0 || rs2_data !== 8'd0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0/0", rs1_data, rs2_data); end
        if (func !== 4'd0 || rd !== 4'd0) begin bad++; $display("FAIL reset_func_rd got=%h/%h exp=0/0", func, rd); end
        rst_n = 1;
        @(posedge clk1); #1;
    endtask

    task automatic test_basic_mul();
        set_issue(FUNC_MUL, 4'd5, 3'd3, 1, 4'd0, 8'd3, 1, 4'd0, 8'd4);
        tick(); idle();
        total += 2;
        if (ex_b !== 1'b0) begin bad++; $display("FAIL mul_early_ex_b got=%b exp=0", ex_b); end
        if (mul_count !== 2'd1) begin bad++; $display("FAIL mul_count_1 got=%0d exp=1", mul_count); end
        tick();
        total += 3;
        if (ex_b !== 1'b1) begin bad++; $display("FAIL mul_ex_b got=%b exp=1", ex_b); end
        if (rs1_data !== 8'd3 || rs2_data !== 8'd4 || func !== FUNC_MUL || rd !== 4'd5 || rob_ind !== 3'd3 || rs_index !== 3'd0)
            begin bad++; $display("FAIL mul_fields got=%h %h %b %0d %0d %0d exp=03 04 0010 5 3 0", rs1_data, rs2_data, func, rd, rob_ind, rs_index); end
        if (mul_count !== 2'd0) begin bad++; $display("FAIL mul_count_0 got=%0d exp=0", mul_count); end
        tick();
        total++;
        if (ex_b !== 1'b0) begin bad++; $display("FAIL mul_strobe_len got=%b exp=0", ex_b); end
        exec_done = 1; tick(); idle();
    endtask

    task automatic test_wakeup();
        set_issue(FUNC_DIV, 4'd6, 3'd2, 1, 4'd0, 8'd9, 0, 4'd7, 8'd0);
        tick(); idle(); tick(); tick();
        total++;
        if (ex_b !== 1'b0) begin bad++; $display("FAIL wake_wait got=%b exp=0", ex_b); end
        cdb_valid = 1; cdb_rd = 4'd7; cdb_data = 16'h0102;
        tick(); idle();
        total++;
        if (ex_b !== 1'b0) begin bad++; $display("FAIL wake_too_early got=%b exp=0", ex_b); end
        tick();
        total += 2;
        if (ex_b !== 1'b1) begin bad++; $display("FAIL wake_ex_b got=%b exp=1", ex_b); end
        if (rs2_data !== 8'h02 || rs1_data !== 8'd9 || func !== FUNC_DIV)
            begin bad++; $display("FAIL wake_fields got=%h %h %b exp=09 02 0011", rs1_data, rs2_data, func); end
        exec_done = 1; tick(); idle();
    endtask

    task automatic test_full();
        for (int k = 0; k < 3; k++) begin
            set_issue(FUNC_MUL, 4'(k), 3'(k), 0, 4'd9, 8'd0, 1, 4'd0, 8'(k + 1));
            tick();
        end
        idle();
        total += 2;
        if (mul_count !== 2'd3) begin bad++; $display("FAIL full_count got=%0d exp=3", mul_count); end
        if (issue_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", issue_ready); end
        set_issue(FUNC_DIV, 4'd15, 3'd7, 1, 4'd0, 8'd1, 1, 4'd0, 8'd1);
        tick(); idle();
        total += 2;
        if (mul_count !== 2'd3) begin bad++; $display("FAIL full_ignore got=%0d exp=3", mul_count); end
        if (ex_b !== 1'b0) begin bad++; $display("FAIL full_no_disp got=%b exp=0", ex_b); end
        cdb_valid = 1; cdb_rd = 4'd9; cdb_data = 16'h00AA;
        tick(); idle();
        tick();
        total += 3;
        if (ex_b !== 1'b1 || rs_index !== 3'd0 || rob_ind !== 3'd0 || rs1_data !== 8'hAA)
            begin bad++; $display("FAIL full_disp got=%b idx=%0d rob=%0d d1=%h exp=1 0 0 aa", ex_b, rs_index, rob_ind, rs1_data); end
        if (mul_count !== 2'd2) begin bad++; $display("FAIL full_count_2 got=%0d exp=2", mul_count); end
        if (issue_ready !== 1'b1) begin bad++; $display("FAIL full_ready_back got=%b exp=1", issue_ready); end
        drain();
    endtask

    task automatic test_age_order();
        set_issue(FUNC_MUL, 4'd1, 3'd1, 1, 4'd0, 8'h11, 1, 4'd0, 8'h12);
        tick(); idle(); tick();
        set_issue(FUNC_MUL, 4'd2, 3'd2, 1, 4'd0, 8'h21, 1, 4'd0, 8'h22); tick();
        set_issue(FUNC_DIV, 4'd3, 3'd3, 1, 4'd0, 8'h31, 0, 4'd14, 8'h00); tick();
        set_issue(FUNC_MUL, 4'd4, 3'd4, 1, 4'd0, 8'h41, 1, 4'd0, 8'h42); tick();
        idle(); exec_done = 1; tick(); exec_done = 0;
        tick();
        total++;
        if (ex_b !== 1'b1 || rs_index !== 3'd0 || rob_ind !== 3'd2)
            begin bad++; $display("FAIL age_first got=%b idx=%0d rob=%0d exp=1 0 2", ex_b, rs_index, rob_ind); end
        set_issue(FUNC_DIV, 4'd5, 3'd5, 1, 4'd0, 8'h51, 1, 4'd0, 8'h52); tick(); idle();
        exec_done = 1; tick(); exec_done = 0;
        tick();
        total++;
        if (ex_b !== 1'b1 || rs_index !== 3'd2 || rob_ind !== 3'd4 || rs1_data !== 8'h41)
            begin bad++; $display("FAIL age_older_idx2 got=%b idx=%0d rob=%0d d1=%h exp=1 2 4 41", ex_b, rs_index, rob_ind, rs1_data); end
        tick(); tick();
        total++;
        if (ex_b !== 1'b0) begin bad++; $display("FAIL age_wait_done got=%b exp=0", ex_b); end
        exec_done = 1; tick(); exec_done = 0;
        total++;
        if (ex_b !== 1'b0) begin bad++; $display("FAIL age_same_edge got=%b exp=0", ex_b); end
        tick();
        total++;
        if (ex_b !== 1'b1 || rs_index !== 3'd0 || rob_ind !== 3'd5)
            begin bad++; $display("FAIL age_second got=%b idx=%0d rob=%0d exp=1 0 5", ex_b, rs_index, rob_ind); end
        drain();
    endtask

    task automatic test_bypass();
        set_issue(FUNC_MUL, 4'd8, 3'd6, 0, 4'd5, 8'd0, 1, 4'd0, 8'd7);
        cdb_valid = 1; cdb_rd = 4'd5; cdb_data = 16'hABCD;
        tick(); idle();
        total++;
        if (ex_b !== 1'b0 || mul_count !== 2'd1) begin bad++; $display("FAIL byp_issue got=%b/%0d exp=0/1", ex_b, mul_count); end
        tick();
        total++;
        if (ex_b !== 1'b1 || rs1_data !== 8'hCD || rs2_data !== 8'd7)
            begin bad++; $display("FAIL byp_capture got=%b %h %h exp=1 cd 07", ex_b, rs1_data, rs2_data); end
        exec_done = 1; tick(); idle();
    endtask

    task automatic test_reset_mid();
        set_issue(FUNC_MUL, 4'd2, 3'd1, 1, 4'd0, 8'h5A, 1, 4'd0, 8'hA5);
        tick(); idle(); tick();
        set_issue(FUNC_MUL, 4'd3, 3'd2, 0, 4'd1, 8'd0, 1, 4'd0, 8'd1); tick();
        set_issue(FUNC_DIV, 4'd4, 3'd3, 0, 4'd2, 8'd0, 1, 4'd0, 8'd1); tick();
        idle();
        total++;
        if (mul_count !== 2'd2) begin bad++; $display("FAIL rmid_held got=%0d exp=2", mul_count); end
        #2 rst_n = 0;
        #1;
        model_reset();
        total += 2;
        if (ex_b !== 1'b0 || mul_count !== 2'd0 || rs_index !== 3'd0)
            begin bad++; $display("FAIL rmid_ctrl got=%b %0d %0d exp=0 0 0", ex_b, mul_count, rs_index); end
        if (rs1_data !== 8'd0 || rs2_data !== 8'd0 || rob_ind !== 3'd0)
            begin bad++; $display("FAIL rmid_data got=%h %h %0d exp=0 0 0", rs1_data, rs2_data, rob_ind); end
        @(negedge clk1); rst_n = 1;
        @(posedge clk1); #1;
        exec_done = 1; tick(); exec_done = 0;
        cdb_valid = 1; cdb_rd = 4'd1; tick();
        cdb_rd = 4'd2; tick(); idle(); tick();
        total++;
        if (ex_b !== 1'b0 || mul_count !== 2'd0) begin bad++; $display("FAIL rmid_discard got=%b/%0d exp=0/0", ex_b, mul_count); end
        set_issue(FUNC_DIV, 4'd9, 3'd4, 1, 4'd0, 8'h66, 1, 4'd0, 8'h77);
        tick(); idle(); tick();
        total++;
        if (ex_b !== 1'b1 || rs1_data !== 8'h66) begin bad++; $display("FAIL rmid_after got=%b %h exp=1 66", ex_b, rs1_data); end
        exec_done = 1; tick(); idle();
    endtask

`ifdef MUL_RS_FLUSH_EN
    task automatic test_flush();
        set_issue(FUNC_MUL, 4'd1, 3'd1, 0, 4'd11, 8'd0, 1, 4'd0, 8'd1); tick();
        set_issue(FUNC_MUL, 4'd2, 3'd2, 1, 4'd0, 8'd2, 1, 4'd0, 8'd2);
        flush = 1;
        tick(); idle();
        total += 2;
        if (mul_count !== 2'd0 || issue_ready !== 1'b1) begin bad++; $display("FAIL flush_count got=%0d/%b exp=0/1", mul_count, issue_ready); end
        if (ex_b !== 1'b0) begin bad++; $display("FAIL flush_no_disp got=%b exp=0", ex_b); end
        tick();
        total++;
        if (ex_b !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%b exp=0", ex_b); end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_func = ($urandom_range(0, 1) == 1) ? FUNC_MUL : FUNC_DIV;
            issue_rd = 4'($urandom); issue_rob_ind = 3'($urandom);
            issue_rs1_rdy = ($urandom_range(0, 1) == 1); issue_rs1_tag = 4'($urandom_range(0, 3));
            issue_rs2_rdy = ($urandom_range(0, 1) == 1); issue_rs2_tag = 4'($urandom_range(0, 3));
            issue_rs1_data = 8'($urandom); issue_rs2_data = 8'($urandom);
            cdb_valid = ($urandom_range(0, 4) < 2); cdb_rd = 4'($urandom_range(0, 3));
            cdb_data = 16'($urandom);
            exec_done = ($urandom_range(0, 3) == 0);
`ifdef MUL_RS_FLUSH_EN
            flush = ($urandom_range(0, 39) == 0);
`endif
            tick();
            total += 4;
            if (ex_b !== m_exb) begin bad++; $display("FAIL rnd_ex_b c=%0d got=%b exp=%b", c, ex_b, m_exb); end
            if (mul_count !== 2'(m_count())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, mul_count, m_count()); end
            if (issue_ready !== (m_count() < 3)) begin bad++; $display("FAIL rnd_ready c=%0d got=%b", c, issue_ready); end
            if (rs_index !== 3'(m_idx) || rs1_data !== m_d1 || rs2_data !== m_d2 || func !== m_func || rd !== m_rd || rob_ind !== m_rob)
                begin bad++; $display("FAIL rnd_fields c=%0d got=%0d %h %h %h %h %0d exp=%0d %h %h %h %h %0d", c,
                    rs_index, rs1_data, rs2_data, func, rd, rob_ind, m_idx, m_d1, m_d2, m_func, m_rd, m_rob); end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic_mul();
        test_wakeup();
        test_full();
        test_age_order();
        test_bypass();
        test_reset_mid();
`ifdef MUL_RS_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_rs_dispatch.md
Name: mul_rs_dispatch

Overview:
- Multiply/divide reservation station for the Tomasulo core.
- Sits directly upstream of the mul/div execution unit.
- Accepts issued MUL/DIV ops from the issue stage, holds them until both operands are ready, and wakes operands from the common data bus (CDB).
- Dispatches the oldest ready entry to the execution unit, one op at a time, using an ex_b/done handshake.

Parameters:
- NUM_ENT, 3, number of station entries.
- DATA_W, 8, operand width.
- REG_W, 4, register index width (rd and operand tags).
- ROB_W, 3, ROB index width; also the rs_index width.

Ports:
- clk1  in  1  Single clock. All state changes on posedge.
- rst_n  in  1  Asynchronous, active-low reset.
- issue_valid  in  1  Issue stage presents an op.
- issue_ready  out  1  Station can accept an op this cycle.
- issue_func  in  4  4'b0010 = MUL, 4'b0011 = DIV.
- issue_rd  in  REG_W  Destination register.
- issue_rob_ind  in  ROB_W  ROB slot.
- issue_rs1_rdy, issue_rs2_rdy  in  1  Operand already available.
- issue_rs1_tag, issue_rs2_tag  in  REG_W  Producer register index when not ready.
- issue_rs1_data, issue_rs2_data  in  DATA_W  Operand value when ready.
- cdb_valid  in  1  Result broadcast this cycle.
- cdb_rd  in  REG_W  Broadcast destination register.
- cdb_data  in  16  Broadcast result. Low DATA_W bits are captured.
- exec_done  in  1  Execution unit finished its current op.
- ex_b  out  1  One-cycle dispatch strobe to the execution unit.
- rs_index  out  ROB_W  Entry index being dispatched.
- rs1_data, rs2_data  out  DATA_W  Dispatched operands.
- func  out  4  Dispatched function code.
- rd  out  REG_W  Dispatched destination register.
- rob_ind  out  ROB_W  Dispatched ROB slot.
- mul_count  out  2  Number of occupied entries (0..NUM_ENT).

Behaviour:
- Reset (async, rst_n low): all entries invalid; busy = 0; ex_b = 0; rs_index, rs1_data, rs2_data, func, rd, rob_ind = 0; mul_count = 0. Asserting reset mid-operation discards all held and in-flight ops. An outstanding exec_done after reset is ignored.
- Entry fields: valid, func, rd, rob_ind, and per operand {rdy, tag, data}, plus an age value.
- Issue: issue_ready = (mul_count < NUM_ENT). No same-cycle credit from a dispatch. On issue_valid && issue_ready, the lowest-index free entry is written and its age is set to youngest.
- Issue/CDB bypass: if cdb_valid and the operand is not ready at issue with tag == cdb_rd, the operand is captured as ready with cdb_data[DATA_W-1:0] in the same cycle.
- Wakeup: each cycle with cdb_valid, every valid entry whose operand has rdy = 0 and tag == cdb_rd sets rdy = 1 and takes the data. All matching entries wake simultaneously.
- Dispatch eligibility: entry valid, both rdy bits set (registered values), and busy = 0.
  - An operand woken this cycle becomes eligible next cycle.
  - Among eligible entries the oldest is chosen. Ties are impossible.
- Dispatch edge:
  - ex_b = 1 for exactly one cycle.
  - Output fields are registered from the chosen entry and held stable until the next dispatch.
  - The entry is freed.
  - busy = 1.
- Minimum latency: an op issued at edge N with both operands ready gives ex_b high in the cycle after edge N+1.
- exec_done clears busy at the next edge. The earliest next dispatch is therefore the edge after that (no same-edge redispatch).
- mul_count: +1 on issue, -1 on dispatch. Simultaneous issue and dispatch leaves it unchanged. It never exceeds NUM_ENT and never underflows.
- Full: issue_ready = 0 and issue_valid is ignored. Empty: no ex_b.
- Ages: maintained as a relative order. Dispatch of the oldest entry shifts the remaining ages. No wrap-around hazard.
- Illegal issue_func (not MUL/DIV): accepted and dispatched unchanged. A bench assertion flags it.

Optional Feature:
- MUL_RS_FLUSH_EN: adds input port flush (1 bit).
- With the macro defined: flush high at an edge invalidates all entries, sets mul_count = 0 and suppresses dispatch that cycle. An issue in the same cycle is dropped. busy is untouched; the in-flight op still completes via exec_done.
- Without the macro: no port and no logic.

Decomposition:
- tomasulo_pkg: DATA_W/REG_W/ROB_W defaults, FUNC_MUL = 4'b0010, FUNC_DIV = 4'b0011, and the station entry struct typedef.
- Sub-module mul_rs_entry: one entry's storage, issue write, CDB wakeup compare and bypass, and ready output. It is instantiated NUM_ENT times.
- Age ordering and oldest-ready selection stay in the top level.

Test Plan:
- Issue MUL rd = 5, rs1 = 3, rs2 = 4, both ready -> ex_b high one cycle later with rs1_data = 3, rs2_data = 4, func = 0010, rob_ind correct, mul_count 1 -> 0.
- Issue DIV with rs2 not ready (tag 7), then CDB rd = 7, data = 16'h0102 -> operand captures 8'h02; ex_b rises the cycle after the wakeup, not before.
- Fill 3 entries -> issue_ready = 0 and a 4th issue_valid is ignored; dispatch plus exec_done frees a slot -> issue_ready returns to 1.
- Two ready entries, older at index 2 and younger at index 0 -> index 2 dispatched first; second ex_b only after exec_done plus one cycle.
- Issue whose operand tag equals cdb_rd in the same cycle -> bypass capture; eligible at the next edge.
- Assert rst_n low while busy with 2 entries held -> all outputs 0 immediately; a later exec_done has no effect. With MUL_RS_FLUSH_EN, a flush pulse gives mul_count = 0 and no ex_b.
